vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels (line total 800).
REQ-005 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines (frame total 525).
REQ-009 clk  input  1  system clock, the single clock of the block.
REQ-010 rst  input  1  reset, synchronous, active-high.
REQ-011 pix_en  input  1  pixel-rate enable from the clock-divider stage; one pixel advance per clk edge with pix_en=1.
REQ-012 hsync  output  1  horizontal sync, active-low.
REQ-013 vsync  output  1  vertical sync, active-low.
REQ-014 video_on  output  1  high while the current pixel is in the visible region.
REQ-015 pixel_x  output  10  current horizontal count, 0..H_total-1.
REQ-016 pixel_y  output  10  current vertical count, 0..V_total-1.
REQ-017 frame_tick  output  1  one-clk pulse marking entry to pixel (0,0).

Function
REQ-018 All state and outputs SHALL change only on rising clk edges; no output SHALL be combinationally derived from pix_en.
REQ-019 With pix_en=0 on an edge, all counters and outputs SHALL hold, except frame_tick, which SHALL be 0.
REQ-020 With pix_en=1, the horizontal counter SHALL increment by 1, wrapping from H_total-1 to 0.
REQ-021 The vertical counter SHALL increment only on the edge where the horizontal counter wraps, wrapping from V_total-1 to 0.
REQ-022 pixel_x and pixel_y SHALL equal the horizontal and vertical counter registers directly, with no added latency.
REQ-023 hsync, vsync and video_on SHALL be registered, computed from the next counter values, so they are cycle-aligned with pixel_x/pixel_y.
REQ-024 hsync SHALL be 0 exactly when pixel_x is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (default 656..751), else 1.
REQ-025 vsync SHALL be 0 exactly when pixel_y is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (default 490..491), else 1.
REQ-026 video_on SHALL be 1 exactly when pixel_x < H_VISIBLE and pixel_y < V_VISIBLE.
REQ-027 frame_tick SHALL be 1 for exactly one clk cycle, following the pix_en edge on which the counters move from (H_total-1, V_total-1) to (0,0).
REQ-028 Counter arithmetic SHALL be 10-bit unsigned; values beyond H_total-1/V_total-1 SHALL never occur.

Reset
REQ-029 rst=1 on a clk edge SHALL take priority over pix_en and force pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, frame_tick=0.
REQ-030 rst asserted mid-line or mid-frame SHALL abort the frame; counting SHALL restart from (0,0) on the first pix_en=1 edge after rst deasserts, with no frame_tick for the aborted frame.

Verification
REQ-031 Reset then pix_en=1 every clk -> pixel_x steps 0,1,2...; at 799 the next edge gives pixel_x=0, pixel_y=1.
REQ-032 pix_en=1 one clk in four (divide-by-4 pattern) -> each count held 4 clks; hsync low for exactly 96x4=384 clks per line.
REQ-033 Run a full frame -> hsync low at x=656..751 only, vsync low at y=490..491 only, video_on high for exactly 640x480=307200 pixel advances.
REQ-034 Counters at (799,524), pix_en=1 -> next edge (0,0), frame_tick=1 for one clk; exactly one frame_tick per 420000 pixel advances.
REQ-035 Counters at (700,300), assert rst for one clk together with pix_en=1 -> outputs at reset values; frame_tick stays 0.
REQ-036 Hold pix_en=0 for 100 clks mid-line at x=655 -> all outputs unchanged; next pix_en edge gives x=656 and hsync=0.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with registered sync,
// blanking and frame-start outputs, advanced by a pixel-rate enable.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] x_next;
  logic [9:0] y_next;

  always_comb begin
    h_wrap = (pixel_x == H_LAST);
    v_wrap = (pixel_y == V_LAST);
    x_next = h_wrap ? 10'd0 : pixel_x + 10'd1;
    y_next = pixel_y;
    if (h_wrap)
      y_next = v_wrap ? 10'd0 : pixel_y + 10'd1;
  end

  // Sync/blank are computed from the next counts so they line up with pixel_x/y.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x    <= 10'd0;
      pixel_y    <= 10'd0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (pix_en) begin
        pixel_x    <= x_next;
        pixel_y    <= y_next;
        hsync      <= !((x_next >= HS_BEG) && (x_next < HS_END));
        vsync      <= !((y_next >= VS_BEG) && (y_next < VS_END));
        video_on   <= (x_next < H_VIS) && (y_next < V_VIS);
        frame_tick <= h_wrap && v_wrap;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance and a small-timing
// instance driven together, checked against a pixel-advance count model.
module tb_vga_sync_gen;

  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVV = 10, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;
  localparam int DHT = 800, DVT = 525;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b0;
  logic       s_hs, s_vs, s_von, s_tick;
  logic       d_hs, d_vs, d_von, d_tick;
  logic [9:0] s_x, s_y, d_x, d_y;

  int checks = 0;
  int errors = 0;
  int n_s = 0, n_d = 0;
  logic tk_s = 1'b0, tk_d = 1'b0;
  int cnt_a, cnt_b;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
    .pixel_x(s_x), .pixel_y(s_y), .frame_tick(s_tick)
  );

  vga_sync_gen u_dflt (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
    .pixel_x(d_x), .pixel_y(d_y), .frame_tick(d_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(int v, int lo, int len);
    return (v >= lo) && (v < lo + len);
  endfunction

  task automatic verify();
    int x, y;
    x = n_s % SHT;
    y = n_s / SHT;
    chk("s_x", 32'(s_x), 32'(x));
    chk("s_y", 32'(s_y), 32'(y));
    chk("s_hsync", 32'(s_hs), 32'(!in_rng(x, SHV + SHF, SHS)));
    chk("s_vsync", 32'(s_vs), 32'(!in_rng(y, SVV + SVF, SVS)));
    chk("s_video", 32'(s_von), 32'(x < SHV && y < SVV));
    chk("s_tick", 32'(s_tick), 32'(tk_s));
    x = n_d % DHT;
    y = n_d / DHT;
    chk("d_x", 32'(d_x), 32'(x));
    chk("d_y", 32'(d_y), 32'(y));
    chk("d_hsync", 32'(d_hs), 32'(!in_rng(x, 656, 96)));
    chk("d_vsync", 32'(d_vs), 32'(!in_rng(y, 490, 2)));
    chk("d_video", 32'(d_von), 32'(x < 640 && y < 480));
    chk("d_tick", 32'(d_tick), 32'(tk_d));
  endtask

  task automatic step(input logic r, input logic e);
    rst = r;
    pix_en = e;
    @(posedge clk);
    if (r) begin
      n_s = 0; n_d = 0; tk_s = 1'b0; tk_d = 1'b0;
    end else if (e) begin
      n_s = (n_s + 1) % (SHT * SVT);
      n_d = (n_d + 1) % (DHT * DVT);
      tk_s = (n_s == 0);
      tk_d = (n_d == 0);
    end else begin
      tk_s = 1'b0; tk_d = 1'b0;
    end
    #1;
    verify();
  endtask

  initial begin
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);

    // Continuous enable across the first default line wrap
    for (int i = 0; i < 799; i++) step(1'b0, 1'b1);
    chk("wrap_x799", 32'(d_x), 32'd799);
    step(1'b0, 1'b1);
    chk("wrap_x0", 32'(d_x), 32'd0);
    chk("wrap_y1", 32'(d_y), 32'd1);

    // Divide-by-4 enable over one full default line
    cnt_a = 0;
    for (int i = 0; i < 3200; i++) begin
      step(1'b0, (i % 4) == 0);
      if (!d_hs) cnt_a++;
    end
    chk("hsync_low_clks", 32'(cnt_a), 32'd384);

    // Full small frame from reset
    step(1'b1, 1'b0);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < SHT * SVT; i++) begin
      step(1'b0, 1'b1);
      if (s_von) cnt_a++;
      if (s_tick) cnt_b++;
    end
    chk("frame_video", 32'(cnt_a), 32'(SHV * SVV));
    chk("frame_ticks", 32'(cnt_b), 32'd1);
    chk("frame_x0", 32'(s_x), 32'd0);

    // Pause just before horizontal sync
    step(1'b1, 1'b0);
    for (int i = 0; i < SHV + SHF - 1; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
    chk("pause_x", 32'(s_x), 32'(SHV + SHF - 1));
    step(1'b0, 1'b1);
    chk("resume_x", 32'(s_x), 32'(SHV + SHF));
    chk("resume_hs", 32'(s_hs), 32'd0);

    // Reset on the last pixel of a frame with enable high
    step(1'b1, 1'b0);
    for (int i = 0; i < SHT * SVT - 1; i++) step(1'b0, 1'b1);
    chk("last_x", 32'(s_x), 32'(SHT - 1));
    chk("last_y", 32'(s_y), 32'(SVT - 1));
    step(1'b1, 1'b1);
    chk("abort_tick", 32'(s_tick), 32'd0);
    chk("abort_video", 32'(s_von), 32'd1);
    step(1'b0, 1'b1);
    chk("restart_x", 32'(s_x), 32'd1);

    // Random enable with sparse resets
    for (int i = 0; i < 4000; i++)
      step($urandom_range(199) == 0, $urandom_range(1) == 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
